// File: rtl/ddr_arbiter_if.sv
// Bus bundle between the video/draw clients, the arbiter and the DDR controller.
// The slave modport is the arbiter side; the master modport is the client/controller side.
interface ddr_arbiter_if;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              drw_req;
    logic [ADDR_W-1:0] drw_addr;
    logic [DATA_W-1:0] drw_wdata;
    logic              drw_ack;
    logic              mem_valid;
    logic [1:0]        mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vid_req, vid_addr, drw_req, drw_addr, drw_wdata,
               mem_ready, mem_done, mem_rdata,
        output vid_ack, vid_rvalid, vid_rdata, drw_ack,
               mem_valid, mem_op, mem_addr, mem_wdata
    );

    modport master (
        output vid_req, vid_addr, drw_req, drw_addr, drw_wdata,
               mem_ready, mem_done, mem_rdata,
        input  vid_ack, vid_rvalid, vid_rdata, drw_ack,
               mem_valid, mem_op, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ddr_arbiter.sv
// Arbitrates video reads, draw writes and periodic auto-refresh onto one DDR
// command port, one transaction in flight, with a bound on video starving draw.
module ddr_arbiter #(
    parameter int unsigned REFRESH_INTERVAL = 1000,
    parameter int unsigned MAX_VID_RUN      = 4
) (
    input logic          clk133_p,
    input logic          rst,
    ddr_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int unsigned RUN_W = (MAX_VID_RUN > 0) ? $clog2(MAX_VID_RUN + 1) : 1;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_REFRESH = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] ref_cnt;
    logic             refresh_pending;
    logic [RUN_W-1:0] vid_run;

    logic wrap_c;
    logic run_full_c;
    logic accept_c;
    logic grant_ref_c;
    logic grant_drw_c;
    logic grant_vid_c;

    // A wrap in an IDLE cycle already wins over client requests at that edge.
    always_comb begin
        wrap_c      = (ref_cnt == CNT_W'(REFRESH_INTERVAL - 1));
        run_full_c  = (vid_run == RUN_W'(MAX_VID_RUN));
        accept_c    = (state == ISSUE) && bus.mem_ready;
        grant_ref_c = (state == IDLE) && (refresh_pending || wrap_c);
        grant_drw_c = (state == IDLE) && !grant_ref_c && bus.drw_req
                      && (run_full_c || !bus.vid_req);
        grant_vid_c = (state == IDLE) && !grant_ref_c && bus.vid_req
                      && !(bus.drw_req && run_full_c);
    end

    // Free-running refresh timer; pending stays set until the refresh command is accepted.
    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            ref_cnt         <= '0;
            refresh_pending <= 1'b0;
        end else begin
            ref_cnt <= wrap_c ? '0 : ref_cnt + CNT_W'(1);
            if (wrap_c) begin
                refresh_pending <= 1'b1;
            end else if (accept_c && (bus.mem_op == OP_REFRESH)) begin
                refresh_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            vid_run        <= '0;
            bus.vid_ack    <= 1'b0;
            bus.drw_ack    <= 1'b0;
            bus.vid_rvalid <= 1'b0;
            bus.vid_rdata  <= '0;
            bus.mem_valid  <= 1'b0;
            bus.mem_op     <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            bus.vid_ack    <= 1'b0;
            bus.drw_ack    <= 1'b0;
            bus.vid_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    // Run length only matters while draw is actually waiting.
                    if (!bus.drw_req || grant_drw_c) begin
                        vid_run <= '0;
                    end else if (grant_vid_c && !run_full_c) begin
                        vid_run <= vid_run + RUN_W'(1);
                    end
                    if (grant_ref_c) begin
                        bus.mem_op    <= OP_REFRESH;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                        bus.mem_valid <= 1'b1;
                        state         <= ISSUE;
                    end else if (grant_drw_c) begin
                        bus.mem_op    <= OP_WRITE;
                        bus.mem_addr  <= bus.drw_addr;
                        bus.mem_wdata <= bus.drw_wdata;
                        bus.mem_valid <= 1'b1;
                        bus.drw_ack   <= 1'b1;
                        state         <= ISSUE;
                    end else if (grant_vid_c) begin
                        bus.mem_op    <= OP_READ;
                        bus.mem_addr  <= bus.vid_addr;
                        bus.mem_wdata <= '0;
                        bus.mem_valid <= 1'b1;
                        bus.vid_ack   <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_done) begin
                        state <= IDLE;
                        if (bus.mem_op == OP_READ) begin
                            bus.vid_rvalid <= 1'b1;
                            bus.vid_rdata  <= bus.mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_arbiter.sv
// Checks ddr_arbiter against a transaction-level reference model plus directed
// scenarios for latency, video/draw fairness, refresh timing, stalls and reset.
module tb_ddr_arbiter;
    localparam int RI  = 16;
    localparam int MVR = 4;

    typedef struct packed {
        logic        vid_ack;
        logic        vid_rvalid;
        logic [31:0] vid_rdata;
        logic        drw_ack;
        logic        mem_valid;
        logic [1:0]  mem_op;
        logic [23:0] mem_addr;
        logic [31:0] mem_wdata;
    } outs_t;

    logic clk133_p = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ddr_arbiter_if bus ();

    ddr_arbiter #(.REFRESH_INTERVAL(RI), .MAX_VID_RUN(MVR)) dut (
        .clk133_p (clk133_p),
        .rst      (rst),
        .bus      (bus)
    );

    always #4 clk133_p = ~clk133_p;

    // Reference model: one transaction record in flight, refresh timer as cycle arithmetic.
    int          cyc;
    bit          m_pend;
    int          m_run;
    bit          m_busy;
    bit          m_acc;
    logic [1:0]  m_op;
    logic [23:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_vack;
    bit          m_dack;
    bit          m_rvalid;
    logic [31:0] m_rdata;

    task automatic model_reset();
        cyc = 0; m_pend = 0; m_run = 0; m_busy = 0; m_acc = 0;
        m_op = '0; m_addr = '0; m_wdata = '0;
        m_vack = 0; m_dack = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic model_step();
        bit wrap;
        bit clear_ref;
        bit take_v;
        bit take_d;
        wrap = ((cyc % RI) == RI - 1);
        clear_ref = 0; take_v = 0; take_d = 0;
        m_vack = 0; m_dack = 0; m_rvalid = 0;
        if (!m_busy) begin
            if (m_pend || wrap) begin
                m_busy = 1; m_op = 2'b10; m_addr = '0; m_wdata = '0;
            end else begin
                if (bus.drw_req && m_run >= MVR) take_d = 1;
                else if (bus.vid_req)            take_v = 1;
                else if (bus.drw_req)            take_d = 1;
                if (take_d) begin
                    m_busy = 1; m_op = 2'b01; m_addr = bus.drw_addr; m_wdata = bus.drw_wdata; m_dack = 1;
                end
                if (take_v) begin
                    m_busy = 1; m_op = 2'b00; m_addr = bus.vid_addr; m_wdata = '0; m_vack = 1;
                end
            end
            if (!bus.drw_req || take_d) m_run = 0;
            else if (take_v)            m_run = (m_run < MVR) ? m_run + 1 : MVR;
        end else if (!m_acc) begin
            if (bus.mem_ready) begin
                m_acc = 1;
                clear_ref = (m_op == 2'b10);
            end
        end else if (bus.mem_done) begin
            m_busy = 0; m_acc = 0;
            if (m_op == 2'b00) begin
                m_rvalid = 1; m_rdata = bus.mem_rdata;
            end
        end
        if (wrap) m_pend = 1;
        else if (clear_ref) m_pend = 0;
        cyc++;
    endtask

    function automatic outs_t model_outs();
        outs_t o;
        o.vid_ack    = m_vack;
        o.vid_rvalid = m_rvalid;
        o.vid_rdata  = m_rdata;
        o.drw_ack    = m_dack;
        o.mem_valid  = m_busy && !m_acc;
        o.mem_op     = m_op;
        o.mem_addr   = m_addr;
        o.mem_wdata  = m_wdata;
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o.vid_ack    = bus.vid_ack;
        o.vid_rvalid = bus.vid_rvalid;
        o.vid_rdata  = bus.vid_rdata;
        o.drw_ack    = bus.drw_ack;
        o.mem_valid  = bus.mem_valid;
        o.mem_op     = bus.mem_op;
        o.mem_addr   = bus.mem_addr;
        o.mem_wdata  = bus.mem_wdata;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk133_p);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic drive_idle();
        bus.vid_req = 0; bus.vid_addr = '0;
        bus.drw_req = 0; bus.drw_addr = '0; bus.drw_wdata = '0;
        bus.mem_ready = 0; bus.mem_done = 0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        model_reset();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        outs_t zero_o;
        zero_o = '0;
        bus.vid_req = 1; bus.drw_req = 1; bus.mem_ready = 1; bus.mem_done = 1;
        bus.mem_rdata = $urandom;
        rst = 0;
        #1;
        rst = 1;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (dut_outs() !== zero_o) begin
                bad++;
                $display("FAIL reset_outs i=%0d got=%h exp=%h", i, dut_outs(), zero_o);
            end
            tick();
        end
        drive_idle();
        rst = 0;
        tick();
        total++;
        if (dut_outs() !== zero_o) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", dut_outs(), zero_o);
        end
    endtask

    task automatic test_video_read();
        do_reset();
        bus.vid_req = 1; bus.vid_addr = 24'h000100;
        tick();
        total++;
        if ({bus.vid_ack, bus.drw_ack, bus.mem_valid, bus.mem_op, bus.mem_addr}
            !== {1'b1, 1'b0, 1'b1, 2'b00, 24'h000100}) begin
            bad++;
            $display("FAIL vid_grant got ack=%b dack=%b valid=%b op=%b addr=%h exp 1 0 1 00 000100",
                     bus.vid_ack, bus.drw_ack, bus.mem_valid, bus.mem_op, bus.mem_addr);
        end
        bus.vid_req = 0;
        tick();
        total++;
        if ({bus.vid_ack, bus.mem_valid, bus.mem_op, bus.mem_addr}
            !== {1'b0, 1'b1, 2'b00, 24'h000100}) begin
            bad++;
            $display("FAIL vid_hold got ack=%b valid=%b op=%b addr=%h exp 0 1 00 000100",
                     bus.vid_ack, bus.mem_valid, bus.mem_op, bus.mem_addr);
        end
        bus.mem_ready = 1;
        tick();
        bus.mem_ready = 0;
        total++;
        if (bus.mem_valid !== 1'b0) begin
            bad++;
            $display("FAIL vid_accept got valid=%b exp 0", bus.mem_valid);
        end
        tick();
        tick();
        total++;
        if (bus.vid_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL vid_early_rvalid got=%b exp 0", bus.vid_rvalid);
        end
        bus.mem_done = 1; bus.mem_rdata = 32'h76543210;
        tick();
        total++;
        if ({bus.vid_rvalid, bus.vid_rdata} !== {1'b1, 32'h76543210}) begin
            bad++;
            $display("FAIL vid_rdata got rvalid=%b data=%h exp 1 76543210", bus.vid_rvalid, bus.vid_rdata);
        end
        bus.mem_done = 0; bus.mem_rdata = 32'hdeadbeef;
        tick();
        total++;
        if ({bus.vid_rvalid, bus.vid_rdata} !== {1'b0, 32'h76543210}) begin
            bad++;
            $display("FAIL vid_rdata_hold got rvalid=%b data=%h exp 0 76543210", bus.vid_rvalid, bus.vid_rdata);
        end
    endtask

    task automatic test_vid_run();
        int          n;
        int          cycles;
        bit          exp_d;
        logic [31:0] wd;
        do_reset();
        wd = $urandom;
        bus.vid_req = 1; bus.vid_addr = 24'($urandom);
        bus.drw_req = 1; bus.drw_addr = 24'($urandom); bus.drw_wdata = wd;
        bus.mem_ready = 1; bus.mem_done = 1;
        n = 0; cycles = 0;
        while (n < 20 && cycles < 400) begin
            tick();
            cycles++;
            total++;
            if (dut_outs() !== model_outs()) begin
                bad++;
                $display("FAIL run_model cyc=%0d got=%h exp=%h", cycles, dut_outs(), model_outs());
            end
            if (bus.vid_ack || bus.drw_ack) begin
                exp_d = (n % 5 == 4);
                total++;
                if (bus.drw_ack !== exp_d || bus.vid_ack !== !exp_d) begin
                    bad++;
                    $display("FAIL grant_order n=%0d got vack=%b dack=%b exp dack=%b", n, bus.vid_ack, bus.drw_ack, exp_d);
                end
                if (exp_d) begin
                    total++;
                    if (bus.mem_wdata !== wd) begin
                        bad++;
                        $display("FAIL drw_wdata n=%0d got=%h exp=%h", n, bus.mem_wdata, wd);
                    end
                    wd = $urandom;
                    bus.drw_wdata = wd;
                end
                n++;
            end
        end
        total++;
        if (n != 20) begin
            bad++;
            $display("FAIL run_timeout got grants=%0d exp 20", n);
        end
        drive_idle();
    endtask

    task automatic test_refresh_only();
        int n;
        int last;
        int acks;
        bit prev_valid;
        do_reset();
        bus.mem_ready = 1; bus.mem_done = 1;
        n = 0; last = -1; acks = 0; prev_valid = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.vid_ack || bus.drw_ack) acks++;
            if (bus.mem_valid && !prev_valid) begin
                total++;
                if (bus.mem_op !== 2'b10) begin
                    bad++;
                    $display("FAIL refresh_op c=%0d got=%b exp 10", c, bus.mem_op);
                end
                if (last >= 0) begin
                    total++;
                    if (c - last != RI) begin
                        bad++;
                        $display("FAIL refresh_period c=%0d got=%0d exp=%0d", c, c - last, RI);
                    end
                end
                last = c;
                n++;
            end
            prev_valid = bus.mem_valid;
        end
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL refresh_count got=%0d exp 6", n);
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL refresh_acks got=%0d exp 0", acks);
        end
        drive_idle();
    endtask

    task automatic test_refresh_vs_video();
        logic [23:0] a;
        bit          seen;
        do_reset();
        bus.mem_ready = 1; bus.mem_done = 1;
        for (int i = 0; i < RI - 1; i++) tick();
        a = 24'($urandom);
        bus.vid_req = 1; bus.vid_addr = a;
        tick();
        total++;
        if ({bus.mem_valid, bus.mem_op, bus.vid_ack} !== {1'b1, 2'b10, 1'b0}) begin
            bad++;
            $display("FAIL ref_first got valid=%b op=%b vack=%b exp 1 10 0", bus.mem_valid, bus.mem_op, bus.vid_ack);
        end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.vid_ack) begin
                seen = 1;
                bus.vid_req = 0;
                total++;
                if ({bus.mem_op, bus.mem_addr} !== {2'b00, a}) begin
                    bad++;
                    $display("FAIL ref_then_vid got op=%b addr=%h exp 00 %h", bus.mem_op, bus.mem_addr, a);
                end
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL ref_vid_timeout got no vid_ack exp one");
        end
        drive_idle();
    endtask

    task automatic test_stall();
        logic [23:0] a;
        int          refs;
        bit          prev_valid;
        do_reset();
        a = 24'($urandom);
        bus.vid_req = 1; bus.vid_addr = a;
        tick();
        bus.vid_req = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            total++;
            if ({bus.mem_valid, bus.mem_op, bus.mem_addr, bus.mem_wdata} !== {1'b1, 2'b00, a, 32'h0}) begin
                bad++;
                $display("FAIL stall_stable i=%0d got valid=%b op=%b addr=%h wd=%h exp 1 00 %h 0",
                         i, bus.mem_valid, bus.mem_op, bus.mem_addr, bus.mem_wdata, a);
            end
        end
        bus.mem_ready = 1;
        tick();
        bus.mem_ready = 0; bus.mem_done = 1; bus.mem_rdata = $urandom;
        tick();
        total++;
        if (bus.vid_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL stall_rvalid got=%b exp 1", bus.vid_rvalid);
        end
        bus.mem_ready = 1;
        refs = 0; prev_valid = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            total++;
            if (dut_outs() !== model_outs()) begin
                bad++;
                $display("FAIL stall_model i=%0d got=%h exp=%h", i, dut_outs(), model_outs());
            end
            if (bus.mem_valid && !prev_valid && bus.mem_op == 2'b10) refs++;
            prev_valid = bus.mem_valid;
        end
        total++;
        if (refs != 1) begin
            bad++;
            $display("FAIL stall_refresh_count got=%0d exp 1", refs);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        outs_t       zero_o;
        logic [23:0] b;
        logic [31:0] d;
        zero_o = '0;
        do_reset();
        bus.vid_req = 1; bus.vid_addr = 24'($urandom);
        tick();
        bus.vid_req = 0; bus.mem_ready = 1;
        tick();
        bus.mem_ready = 0;
        tick();
        rst = 1;
        model_reset();
        #1;
        total++;
        if (dut_outs() !== zero_o) begin
            bad++;
            $display("FAIL midrst_outs got=%h exp=%h", dut_outs(), zero_o);
        end
        tick();
        rst = 0;
        bus.mem_done = 1; bus.mem_rdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dut_outs() !== zero_o) begin
                bad++;
                $display("FAIL midrst_spurious i=%0d got=%h exp=%h", i, dut_outs(), zero_o);
            end
        end
        bus.mem_done = 0;
        b = 24'($urandom); d = $urandom;
        bus.vid_req = 1; bus.vid_addr = b;
        tick();
        total++;
        if ({bus.vid_ack, bus.mem_valid, bus.mem_op, bus.mem_addr} !== {1'b1, 1'b1, 2'b00, b}) begin
            bad++;
            $display("FAIL midrst_regrant got ack=%b valid=%b op=%b addr=%h exp 1 1 00 %h",
                     bus.vid_ack, bus.mem_valid, bus.mem_op, bus.mem_addr, b);
        end
        bus.vid_req = 0; bus.mem_ready = 1;
        tick();
        bus.mem_ready = 0; bus.mem_done = 1; bus.mem_rdata = d;
        tick();
        total++;
        if ({bus.vid_rvalid, bus.vid_rdata} !== {1'b1, d}) begin
            bad++;
            $display("FAIL midrst_read got rvalid=%b data=%h exp 1 %h", bus.vid_rvalid, bus.vid_rdata, d);
        end
        drive_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.vid_req   = ($urandom_range(0, 3) != 0);
            bus.vid_addr  = 24'($urandom);
            bus.drw_req   = ($urandom_range(0, 2) != 0);
            bus.drw_addr  = 24'($urandom);
            bus.drw_wdata = $urandom;
            bus.mem_ready = ($urandom_range(0, 2) != 0);
            bus.mem_done  = ($urandom_range(0, 2) != 0);
            bus.mem_rdata = $urandom;
            rst = ($urandom_range(0, 499) == 0);
            tick();
            total++;
            if (dut_outs() !== model_outs()) begin
                bad++;
                $display("FAIL random_model i=%0d got=%h exp=%h", i, dut_outs(), model_outs());
            end
        end
        rst = 0;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_video_read();
        test_vid_run();
        test_refresh_only();
        test_refresh_vs_video();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
